// File: rtl/sdram_arbiter.sv
// SDRAM pin arbiter: holds traffic until init completes, then grants
// refresh first and alternates write/read, muxing the granted command bus.
module sdram_arbiter #(
  parameter int         DATA_W  = 16,
  parameter int         ADDR_W  = 13,
  parameter int         BA_W    = 2,
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sdram_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {
    IDLE, ARBIT, AREF, WRITE, READ
  } state_t;

  state_t state_q, state_d;
  logic   aref_en_q, aref_en_d;
  logic   wr_en_q, wr_en_d;
  logic   rd_en_q, rd_en_d;
  logic   last_wr_q, last_wr_d;

  logic [3:0]        cmd;
  logic [BA_W-1:0]   ba;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    state_d   = state_q;
    aref_en_d = aref_en_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    last_wr_d = last_wr_q;
    unique case (state_q)
      IDLE: begin
        if (init_end) state_d = ARBIT;
      end
      ARBIT: begin
        if (aref_req) begin
          state_d   = AREF;
          aref_en_d = 1'b1;
        end else if (wr_req && (!rd_req || !last_wr_q)) begin
          state_d = WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = READ;
          rd_en_d = 1'b1;
        end
      end
      AREF: begin
        if (aref_end) begin
          state_d   = ARBIT;
          aref_en_d = 1'b0;
        end
      end
      WRITE: begin
        if (wr_end) begin
          state_d   = ARBIT;
          wr_en_d   = 1'b0;
          last_wr_d = 1'b1;
        end
      end
      READ: begin
        if (rd_end) begin
          state_d   = ARBIT;
          rd_en_d   = 1'b0;
          last_wr_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= IDLE;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Pins follow state directly so a grant sees its bus on the pins at once
  always_comb begin
    cmd  = CMD_NOP;
    ba   = '1;
    addr = '1;
    unique case (state_q)
      IDLE: begin
        cmd  = init_cmd;
        ba   = init_ba;
        addr = init_addr;
      end
      AREF: begin
        cmd  = aref_cmd;
        ba   = aref_ba;
        addr = aref_addr;
      end
      WRITE: begin
        cmd  = wr_cmd;
        ba   = wr_ba;
        addr = wr_addr;
      end
      READ: begin
        cmd  = rd_cmd;
        ba   = rd_ba;
        addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_ba     = ba;
  assign sdram_addr   = addr;
  assign sdram_cke    = 1'b1;
  assign sdram_dq_out = wr_data;
  assign sdram_dq_oe  = (state_q == WRITE) && wr_sdram_en;
  assign aref_en      = aref_en_q;
  assign wr_en        = wr_en_q;
  assign rd_en        = rd_en_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios then random traffic,
// every cycle compared against an owner/turn reference model.
module tb_sdram_arbiter;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int BW = 2;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  // index 0 = init, 1 = refresh, 2 = write, 3 = read
  logic          init_end;
  logic [3:0]    cmd_v  [4];
  logic [BW-1:0] ba_v   [4];
  logic [AW-1:0] addr_v [4];
  logic          req_v  [4];
  logic          end_v  [4];
  logic [DW-1:0] wr_data;
  logic          wr_sdram_en;

  logic          aref_en, wr_en, rd_en, sdram_cke;
  logic          sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BW-1:0] sdram_ba;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_dq_out;
  logic          sdram_dq_oe;

  sdram_arbiter dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(cmd_v[0]), .init_ba(ba_v[0]), .init_addr(addr_v[0]),
    .aref_req(req_v[1]), .aref_end(end_v[1]),
    .aref_cmd(cmd_v[1]), .aref_ba(ba_v[1]), .aref_addr(addr_v[1]),
    .wr_req(req_v[2]), .wr_end(end_v[2]),
    .wr_cmd(cmd_v[2]), .wr_ba(ba_v[2]), .wr_addr(addr_v[2]),
    .wr_data(wr_data), .wr_sdram_en(wr_sdram_en),
    .rd_req(req_v[3]), .rd_end(end_v[3]),
    .rd_cmd(cmd_v[3]), .rd_ba(ba_v[3]), .rd_addr(addr_v[3]),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  // reference model: who owns the pins, and who was served last of W/R
  bit    m_init;
  int    m_owner;
  bit    m_last_wr;
  bit    want [4];
  bit    hold [4];
  int    cnt  [4];
  int    blen_min, blen_max;
  bit    spur, fixed_dq, rnd_req, rnd_init;
  string ord;
  logic [2:0] prev_g;
  int    checks, errors;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [18:0] ep;
    int sel;
    sel = m_init ? m_owner : 0;
    if (m_init && m_owner == 0) ep = {4'b0111, 2'b11, 13'h1FFF};
    else ep = {cmd_v[sel], ba_v[sel], addr_v[sel]};
    check("pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                   sdram_ba, sdram_addr}, 32'(ep));
    check("grants", {aref_en, wr_en, rd_en},
          {m_owner == 1, m_owner == 2, m_owner == 3});
    check("dq_oe", sdram_dq_oe, (m_owner == 2) && wr_sdram_en);
    check("dq_out", sdram_dq_out, wr_data);
    check("cke", sdram_cke, 1);
  endtask

  task automatic cycle();
    logic [2:0] g;
    int nxt;
    for (int u = 0; u < 4; u++) begin
      cmd_v[u]  = 4'($urandom);
      ba_v[u]   = BW'($urandom);
      addr_v[u] = AW'($urandom);
    end
    wr_data     = fixed_dq ? 16'hA5A5 : DW'($urandom);
    wr_sdram_en = fixed_dq ? 1'b1 : 1'($urandom);
    if (rnd_init && m_init) init_end = 1'($urandom);
    for (int u = 1; u < 4; u++) begin
      req_v[u] = want[u] | hold[u];
      if (m_owner == u) end_v[u] = (cnt[u] == 0);
      else end_v[u] = spur && ($urandom_range(0, 1) == 0);
    end
    @(negedge sys_clk);
    compare_all();
    g = {aref_en, wr_en, rd_en};
    if (g != prev_g && g != 3'b000) begin
      if (g[2]) ord = {ord, "A"};
      else if (g[1]) ord = {ord, "W"};
      else ord = {ord, "R"};
    end
    prev_g = g;
    @(posedge sys_clk);
    if (!m_init) begin
      if (init_end) m_init = 1;
    end else if (m_owner == 0) begin
      nxt = 0;
      if (req_v[1]) nxt = 1;
      else if (req_v[2] && req_v[3]) nxt = m_last_wr ? 3 : 2;
      else if (req_v[2]) nxt = 2;
      else if (req_v[3]) nxt = 3;
      if (nxt != 0) begin
        m_owner   = nxt;
        want[nxt] = 0;
        cnt[nxt]  = $urandom_range(blen_min, blen_max);
      end
    end else if (end_v[m_owner]) begin
      if (m_owner == 2) m_last_wr = 1;
      if (m_owner == 3) m_last_wr = 0;
      m_owner = 0;
    end else begin
      cnt[m_owner]--;
    end
    if (rnd_req)
      for (int u = 1; u < 4; u++)
        if (m_owner != u && !want[u] && $urandom_range(0, 3) == 0)
          want[u] = 1;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_owner(input int t);
    int n;
    n = 0;
    while (m_owner != t && n < 60) begin
      cycle();
      n++;
    end
    check("wait_owner_timeout", m_owner == t, 1);
  endtask

  task automatic apply_reset();
    sys_rst = 1'b0;
    #1;
    m_init    = 0;
    m_owner   = 0;
    m_last_wr = 0;
    for (int u = 0; u < 4; u++) begin
      want[u] = 0;
      cnt[u]  = 0;
    end
    compare_all();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    prev_g  = 3'b000;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_init = 0; m_owner = 0; m_last_wr = 0;
    blen_min = 0; blen_max = 3;
    spur = 0; fixed_dq = 0; rnd_req = 0; rnd_init = 0;
    prev_g = 3'b000; ord = "";
    init_end = 1'b0; wr_data = '0; wr_sdram_en = 1'b0;
    for (int u = 0; u < 4; u++) begin
      cmd_v[u] = '0; ba_v[u] = '0; addr_v[u] = '0;
      req_v[u] = 1'b0; end_v[u] = 1'b0;
      want[u] = 0; hold[u] = 0; cnt[u] = 0;
    end
    sys_rst = 1'b1;
    #2;
    apply_reset();

    // held in IDLE: refresh request is ignored until init completes
    hold[1] = 1;
    run(50);
    check("t1_no_grant", {aref_en, wr_en, rd_en}, 0);
    hold[1] = 0;

    // refresh first, then write, then read
    init_end = 1'b1;
    want[1] = 1; want[2] = 1; want[3] = 1;
    ord = "";
    run(30);
    assert (ord == "AWR") else begin
      errors++;
      $error("FAIL t2_order: got %s expected AWR", ord);
    end
    checks++;

    // continuous write+read requests alternate
    hold[2] = 1; hold[3] = 1;
    ord = "";
    for (int n = 0; n < 60 && ord.len() < 4; n++) cycle();
    hold[2] = 0; hold[3] = 0;
    assert (ord == "WRWR") else begin
      errors++;
      $error("FAIL t3_order: got %s expected WRWR", ord);
    end
    checks++;
    run(12);

    // refresh raised mid-write beats the waiting read
    blen_min = 3; blen_max = 5;
    ord = "";
    want[2] = 1;
    wait_owner(2);
    want[1] = 1; want[3] = 1;
    run(30);
    assert (ord == "WAR") else begin
      errors++;
      $error("FAIL t4_order: got %s expected WAR", ord);
    end
    checks++;
    run(8);

    // DQ enable only in WRITE; stray ends from other units ignored
    fixed_dq = 1; spur = 1;
    want[2] = 1;
    wait_owner(2);
    cycle();
    check("t5_dq_oe_wr", sdram_dq_oe, 1);
    check("t5_dq_out", sdram_dq_out, 16'hA5A5);
    check("t5_wr_en", wr_en, 1);
    want[3] = 1;
    wait_owner(3);
    check("t5_dq_oe_rd", sdram_dq_oe, 0);
    fixed_dq = 0; spur = 0;

    // async reset in the middle of a read burst
    check("t6_rd_en_before", rd_en, 1);
    #2;
    apply_reset();
    check("t6_rd_en_after", rd_en, 0);
    blen_min = 0;
    run(6);

    // random traffic with stray ends and init_end wiggle after init
    rnd_req = 1; spur = 1; rnd_init = 1; blen_max = 5;
    run(3000);
    #3;
    apply_reset();
    init_end = 1'b1;
    run(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
